packet_display_arbiter: RTL and testbench

//  Round-robin scheduler sharing the six-digit display path among NUM_SRC packet sources.

---
 rtl/pkt_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 32 +++
 rtl/packet_display_arbiter.sv | 86 ++++++++
 tb/tb_packet_display_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_arb_pkg.sv
// Shared types for the packet display arbiter.
// Optional build macro: PKT_ARB_BLANK_EN (blank the display when idle).
package pkt_arb_pkg;

  localparam int PKT_W_DEF = 24;

  typedef logic [PKT_W_DEF-1:0] pkt_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_DWELL
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational.
module rr_pick #(
  parameter int NUM_SRC = 6,
  localparam int SRC_W = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt_onehot,
  output logic [SRC_W-1:0]   gnt_idx,
  output logic               any
);

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (req[idx]) begin
        gnt_onehot      = '0;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = SRC_W'(idx);
        any             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_display_arbiter.sv
// Round-robin share of the six-digit display among packet sources.
// Optional build macro: PKT_ARB_BLANK_EN (blank the display when idle).
import pkt_arb_pkg::*;

module packet_display_arbiter #(
  parameter int NUM_SRC      = 6,
  parameter int PKT_W        = PKT_W_DEF,
  parameter int DWELL_CYCLES = 50_000_000,
  localparam int SRC_W = $clog2(NUM_SRC),
  localparam int CNT_W = $clog2(DWELL_CYCLES + 1)
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic [NUM_SRC-1:0]       req_valid,
  input  logic [NUM_SRC*PKT_W-1:0] req_data,
  output logic [NUM_SRC-1:0]       req_ready,
  output logic [PKT_W-1:0]         packet_out,
  output logic [SRC_W-1:0]         src_id,
  output logic                     display_valid,
  output logic                     busy
);

  arb_state_t         state, state_nxt;
  logic [SRC_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_SRC-1:0] gnt_onehot;
  logic [SRC_W-1:0]   gnt_idx;
  logic               any;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= ARB_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    busy      = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        req_ready = gnt_onehot;
        if (any) state_nxt = ARB_DWELL;
      end
      ARB_DWELL: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = ARB_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      rr_ptr        <= '0;
      cnt           <= '0;
      packet_out    <= '0;
      src_id        <= '0;
      display_valid <= 1'b0;
    end else if (state == ARB_IDLE) begin
      if (any) begin
        packet_out    <= req_data[int'(gnt_idx)*PKT_W +: PKT_W];
        src_id        <= gnt_idx;
        display_valid <= 1'b1;
        cnt           <= CNT_W'(DWELL_CYCLES - 1);
        rr_ptr        <= (gnt_idx == SRC_W'(NUM_SRC - 1)) ?
                         '0 : gnt_idx + SRC_W'(1);
      end
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
`ifdef PKT_ARB_BLANK_EN
    end else if (!(|req_valid)) begin
      display_valid <= 1'b0;
      packet_out    <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_packet_display_arbiter.sv
// Randomized and directed bench for packet_display_arbiter.
// Reference model tracks grants as dwell windows and a rotating pointer.
module tb_packet_display_arbiter;

  localparam int N = 6;
  localparam int W = 24;
  localparam int D = 4;
  localparam int SW = $clog2(N);

  logic           clock = 1'b0;
  logic           clear_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   packet_out;
  logic [SW-1:0]  src_id;
  logic           display_valid;
  logic           busy;

  packet_display_arbiter #(
    .NUM_SRC(N), .PKT_W(W), .DWELL_CYCLES(D)
  ) dut (
    .clock         (clock),
    .clear_n       (clear_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .packet_out    (packet_out),
    .src_id        (src_id),
    .display_valid (display_valid),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // stimulus state
  logic         v_arr [N];
  logic [W-1:0] d_arr [N];
  bit           drop_on_grant;

  // reference model
  int           m_left;
  int           m_ptr;
  int           m_src;
  logic [W-1:0] m_pkt;
  logic         m_dv;
  int           grants[$];

  function automatic void model_reset();
    m_left = 0; m_ptr = 0; m_src = 0; m_pkt = '0; m_dv = 1'b0;
  endfunction

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v_arr[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit any_valid();
    for (int i = 0; i < N; i++) if (v_arr[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outputs(input string tag);
    logic [N-1:0] exp_rdy;
    int w;
    exp_rdy = '0;
    w = pick();
    if (m_left == 0 && w >= 0) exp_rdy[w] = 1'b1;
    check({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
    check({tag, ".busy"}, 32'(busy), 32'(m_left > 0));
    check({tag, ".pkt"}, 32'(packet_out), 32'(m_pkt));
    check({tag, ".src"}, 32'(src_id), 32'(m_src));
    check({tag, ".dv"}, 32'(display_valid), 32'(m_dv));
  endtask

  // One clock: drive at negedge, check, then advance the model past posedge.
  task automatic cycle(input string tag);
    int w;
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      req_valid[i] = v_arr[i];
      req_data[i*W +: W] = d_arr[i];
    end
    #1;
    check_outputs(tag);
    w = pick();
    if (m_left == 0) begin
      if (w >= 0) begin
        m_pkt = d_arr[w]; m_src = w; m_dv = 1'b1;
        m_left = D; m_ptr = (w + 1) % N;
        grants.push_back(w);
        if (drop_on_grant) v_arr[w] = 1'b0;
      end
    end else begin
      m_left--;
`ifdef PKT_ARB_BLANK_EN
      if (m_left == 0 && !any_valid()) begin
        m_dv = 1'b0; m_pkt = '0;
      end
`endif
    end
  endtask

  task automatic set_valid(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) v_arr[i] = v[i];
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      v_arr[i] = 1'b0;
      d_arr[i] = W'(32'h100000 * (i + 1) + i);
    end
    req_valid = '0;
    req_data = '0;
    drop_on_grant = 1'b1;
    model_reset();

    // reset held three cycles
    clear_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_outputs("reset");
    #2 clear_n = 1'b1;
    repeat (3) cycle("idle");

    // single source 2
    d_arr[2] = 24'hABC123;
    set_valid(6'b000100);
    grants.delete();
    repeat (D + 3) cycle("single");
    check("single.pkt_const", 32'(packet_out), 32'h00ABC123);
    check("single.grants", 32'(grants.size()), 32'd1);

    // all valid held: strict rotation starting at 3
    drop_on_grant = 1'b0;
    set_valid(6'b111111);
    grants.delete();
    repeat (7 * (D + 1)) cycle("all");
    check("all.count", 32'(grants.size()), 32'd7);
    for (int g = 0; g < grants.size() && g < 7; g++)
      check("all.seq", 32'(grants[g]), 32'((3 + g) % N));
    set_valid('0);
    repeat (D + 1) cycle("all_drain");

    // wrap: reach ptr 5 via source 4, then 5 and 0 both request
    drop_on_grant = 1'b1;
    set_valid(6'b010000);
    repeat (D + 1) cycle("wrap_pre");
    set_valid(6'b100001);
    grants.delete();
    repeat (2 * (D + 1)) cycle("wrap");
    check("wrap.n", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) begin
      check("wrap.first", 32'(grants[0]), 32'd5);
      check("wrap.second", 32'(grants[1]), 32'd0);
    end

    // reset mid-dwell at cnt=2
    set_valid(6'b001000);
    cycle("rst_pre");
    cycle("rst_pre");
    check("rst.model_left", 32'(m_left), 32'(D - 1));
    @(negedge clock);
    #2 clear_n = 1'b0;
    #1;
    model_reset();
    check("rst.pkt", 32'(packet_out), 32'd0);
    check("rst.src", 32'(src_id), 32'd0);
    check("rst.dv", 32'(display_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    #2 clear_n = 1'b1;
    set_valid(6'b011010);
    grants.delete();
    repeat (2) cycle("rst_post");
    check("rst.first_grant", grants.size() > 0 ? 32'(grants[0]) : 32'hFFFF,
          32'd1);
    set_valid('0);
    repeat (D + 2) cycle("rst_drain");

    // single grant then idle at dwell end
    d_arr[4] = 24'h5A5A5A;
    set_valid(6'b010000);
    repeat (D + 3) cycle("hold");
`ifdef PKT_ARB_BLANK_EN
    check("hold.dv", 32'(display_valid), 32'd0);
    check("hold.pkt", 32'(packet_out), 32'd0);
`else
    check("hold.dv", 32'(display_valid), 32'd1);
    check("hold.pkt", 32'(packet_out), 32'h005A5A5A);
`endif
    check("hold.src", 32'(src_id), 32'd4);

    // randomized traffic obeying the handshake
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v_arr[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            v_arr[i] = 1'b1;
            d_arr[i] = W'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          v_arr[i] = 1'b0;
        end
      end
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
